mem_access: RTL and testbench

- MEM stage of the 5-stage RV32I pipeline, directly downstream of the execute stage and its EX/MEM pipeline register.
- Turns ALU results and load/store requests into byte-serial transactions on the 8-bit RAM port.
- Holds the pipeline with stall_req until a memory operation finishes.
- Drives the write-back bundle into the MEM/WB register.

---
 rtl/mem_access_if.sv | 24 ++
 rtl/mem_access.sv | 175 +++++++++++++++++
 tb/tb_mem_access.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Byte-serial RAM port between the MEM stage and data memory.
// mem_din returns the byte for the address driven in the previous cycle.
interface mem_access_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] mem_a;
    logic [7:0]        mem_dout;
    logic              mem_wr;
    logic [7:0]        mem_din;

    modport master (
        output mem_a,
        output mem_dout,
        output mem_wr,
        input  mem_din
    );

    modport slave (
        input  mem_a,
        input  mem_dout,
        input  mem_wr,
        output mem_din
    );
endinterface

// File: rtl/mem_access.sv
// MEM stage of the RV32I pipeline: serialises loads/stores onto an 8-bit RAM
// port, stalls upstream until the access completes, and feeds MEM/WB.
module mem_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [4:0]        ex_rd,
    input  logic              ex_rd_enable,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  logic [2:0]        mem_funct3,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    mem_access_if.master      ram,
    output logic              stall_req,
    output logic [4:0]        wb_rd,
    output logic              wb_rd_enable,
    output logic [DATA_W-1:0] wb_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        cnt;
    logic [1:0]        cnt_nxt;
    logic [1:0]        last_idx;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] wdata_p1;
    logic              we_p1;
    logic [2:0]        funct3_p1;
    logic [DATA_W-1:0] rbuf;
    logic [7:0]        skid;
    logic              skid_vld;
    logic [7:0]        rd_byte;
    logic [ADDR_W-1:0] mem_a_q;
    logic [7:0]        mem_dout_q;
    logic              mem_wr_q;

    function automatic logic [1:0] last_byte_idx(input logic [2:0] f3);
        logic [1:0] r;
        case (f3[1:0])
            2'b00:   r = 2'd0;
            2'b01:   r = 2'd1;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] w,
                                             input logic [1:0]        idx);
        return w[8*idx +: 8];
    endfunction

    function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] w,
                                                   input logic [1:0]        idx,
                                                   input logic [7:0]        b);
        logic [DATA_W-1:0] r;
        r = w;
        r[8*idx +: 8] = b;
        return r;
    endfunction

    // funct3[2] selects zero-extension (LBU/LHU); reserved widths load a word.
    function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] w,
                                                   input logic [2:0]        f3);
        logic signed [7:0]  b8;
        logic signed [15:0] h16;
        logic [DATA_W-1:0]  r;
        b8  = w[7:0];
        h16 = w[15:0];
        case (f3[1:0])
            2'b00:   r = f3[2] ? DATA_W'(w[7:0])  : DATA_W'(b8);
            2'b01:   r = f3[2] ? DATA_W'(w[15:0]) : DATA_W'(h16);
            default: r = w;
        endcase
        return r;
    endfunction

    assign cnt_nxt = cnt + 2'd1;

    // While frozen the address holds, so mem_din moves on to the held
    // address; the skid keeps the byte that belonged to the previous one.
    assign rd_byte = skid_vld ? skid : ram.mem_din;

    // ---- request latch (data only, no reset) ----
    always_ff @(posedge clk) begin
        if (rdy && state == S_IDLE && mem_valid) begin
            addr_p1   <= mem_addr;
            wdata_p1  <= mem_wdata;
            we_p1     <= mem_we;
            funct3_p1 <= mem_funct3;
            last_idx  <= last_byte_idx(mem_funct3);
        end
        if (!rdy && !skid_vld) begin
            skid <= ram.mem_din;
        end
    end

    // ---- access sequencer and registered RAM outputs ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= 2'd0;
            rbuf       <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            skid_vld   <= 1'b0;
        end else if (!rdy) begin
            skid_vld <= 1'b1;
        end else begin
            skid_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_valid) begin
                        cnt        <= 2'd0;
                        rbuf       <= '0;
                        mem_a_q    <= mem_addr;
                        mem_wr_q   <= mem_we;
                        mem_dout_q <= mem_wdata[7:0];
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!we_p1 && cnt != 2'd0) begin
                        rbuf <= put_byte(rbuf, cnt - 2'd1, rd_byte);
                    end
                    if (cnt == last_idx) begin
                        mem_a_q    <= '0;
                        mem_dout_q <= 8'd0;
                        mem_wr_q   <= 1'b0;
                        state      <= we_p1 ? S_DONE : S_DRAIN;
                    end else begin
                        cnt        <= cnt_nxt;
                        mem_a_q    <= addr_p1 + ADDR_W'(cnt_nxt);
                        mem_dout_q <= pick_byte(wdata_p1, cnt_nxt);
                    end
                end
                S_DRAIN: begin
                    rbuf  <= put_byte(rbuf, last_idx, rd_byte);
                    state <= S_DONE;
                end
                S_DONE: begin
                    cnt   <= 2'd0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---- combinational outputs ----
    assign ram.mem_a    = mem_a_q;
    assign ram.mem_dout = mem_dout_q;
    assign ram.mem_wr   = mem_wr_q && rdy;

    assign stall_req    = mem_valid && (state != S_DONE);
    assign wb_rd        = ex_rd;
    assign wb_rd_enable = ex_rd_enable;

    always_comb begin
        wb_data = ex_result;
        if (state == S_DONE && !we_p1) begin
            wb_data = load_ext(rbuf, funct3_p1);
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomised scoreboard bench for mem_access with a byte-array RAM model.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [4:0]  ex_rd;
    logic        ex_rd_enable;
    logic [31:0] ex_result;
    logic        mem_valid;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stall_req;
    logic [4:0]  wb_rd;
    logic        wb_rd_enable;
    logic [31:0] wb_data;

    mem_access_if #(.ADDR_W(32)) ram ();

    mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .ex_rd        (ex_rd),
        .ex_rd_enable (ex_rd_enable),
        .ex_result    (ex_result),
        .mem_valid    (mem_valid),
        .mem_we       (mem_we),
        .mem_funct3   (mem_funct3),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .ram          (ram),
        .stall_req    (stall_req),
        .wb_rd        (wb_rd),
        .wb_rd_enable (wb_rd_enable),
        .wb_data      (wb_data)
    );

    always #5 clk = ~clk;

    // RAM model: 256 bytes aliased on addr[7:0], one-cycle read latency
    logic [7:0] seed    [256];
    logic [7:0] ram_mem [256];
    logic       written [256];
    logic [7:0] ref_mem [256];
    logic [7:0] din_q;
    logic       ram_clr;

    function automatic logic [7:0] ram_rd(input logic [7:0] a);
        return written[a] ? ram_mem[a] : seed[a];
    endfunction

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) written[i] <= 1'b0;
        end else if (ram.mem_wr) begin
            ram_mem[ram.mem_a[7:0]] <= ram.mem_dout;
            written[ram.mem_a[7:0]] <= 1'b1;
        end
        din_q <= ram_rd(ram.mem_a[7:0]);
    end
    assign ram.mem_din = din_q;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        en;
        int          stall;
    } wb_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    wb_t  wb_q  [$];
    wb_t  alu_q [$];
    wr_t  wr_q  [$];
    logic alu_chk;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write, a
    // completed memory op, or a pass-through cycle.
    initial begin
        int sc;
        wb_t e;
        wr_t w;
        sc = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sc = 0;
            end else begin
                if (ram.mem_wr) begin
                    chk("wr_while_frozen", {31'd0, rdy}, 32'd1);
                    if (wr_q.size() == 0) begin
                        chk("unexpected_write", ram.mem_a, 32'hxxxxxxxx);
                    end else begin
                        w = wr_q.pop_front();
                        chk("wr_addr", ram.mem_a, w.a);
                        chk("wr_byte", {24'd0, ram.mem_dout}, {24'd0, w.d});
                    end
                end
                if (mem_valid) begin
                    if (stall_req) begin
                        sc++;
                    end else if (wb_q.size() == 0) begin
                        chk("unexpected_done", wb_data, 32'hxxxxxxxx);
                    end else begin
                        e = wb_q.pop_front();
                        chk("wb_data", wb_data, e.data);
                        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                        chk("wb_en", {31'd0, wb_rd_enable}, {31'd0, e.en});
                        chk("stall_cycles", 32'(sc), 32'(e.stall));
                        sc = 0;
                    end
                end
                if (alu_chk && alu_q.size() != 0) begin
                    e = alu_q.pop_front();
                    chk("alu_data", wb_data, e.data);
                    chk("alu_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                    chk("alu_en", {31'd0, wb_rd_enable}, {31'd0, e.en});
                    chk("alu_stall", {31'd0, stall_req}, 32'd0);
                end
            end
        end
    end

    task automatic summary_and_finish();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    task automatic issue_alu(input logic [31:0] res, input logic [4:0] rd, input logic en);
        wb_t e;
        mem_valid    = 1'b0;
        ex_result    = res;
        ex_rd        = rd;
        ex_rd_enable = en;
        e.data = res; e.rd = rd; e.en = en; e.stall = 0;
        alu_q.push_back(e);
        alu_chk = 1'b1;
        @(posedge clk); #1;
        alu_chk = 1'b0;
    endtask

    // Reference: byte count from funct3, little-endian bytes at addr+k mod 2^32.
    task automatic issue_mem(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input int lows, input int off);
        int          n;
        logic [31:0] w;
        logic [31:0] ak;
        wb_t         e;
        wr_t         x;
        bit          done;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        e.rd  = 5'($urandom_range(1, 31));
        e.en  = !we;
        ex_result = $urandom;
        w = 32'd0;
        for (int k = 0; k < n; k++) begin
            ak = addr + 32'(k);
            if (we) begin
                x.a = ak;
                x.d = wdata[8*k +: 8];
                wr_q.push_back(x);
                ref_mem[ak[7:0]] = x.d;
            end else begin
                w[8*k +: 8] = ref_mem[ak[7:0]];
            end
        end
        if (we) begin
            e.data  = ex_result;
            e.stall = n + 1 + lows;
        end else begin
            if (n == 1)      e.data = f3[2] ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            else if (n == 2) e.data = f3[2] ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            else             e.data = w;
            e.stall = n + 2 + lows;
        end
        wb_q.push_back(e);
        ex_rd        = e.rd;
        ex_rd_enable = e.en;
        mem_valid    = 1'b1;
        mem_we       = we;
        mem_funct3   = f3;
        mem_addr     = addr;
        mem_wdata    = wdata;
        done = 1'b0;
        for (int c = 0; c < 64; c++) begin
            rdy = (c >= off && c < off + lows) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (!stall_req) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: stall_req still 1 after 64 cycles, expected DONE");
            summary_and_finish();
        end
        @(posedge clk); #1;
        mem_valid = 1'b0;
        rdy       = 1'b1;
    endtask

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          s;
        int          lows;
        rst = 1'b1; rdy = 1'b1; alu_chk = 1'b0; ram_clr = 1'b1;
        ex_rd = 5'd0; ex_rd_enable = 1'b0; ex_result = 32'd0;
        mem_valid = 1'b0; mem_we = 1'b0; mem_funct3 = 3'd0;
        mem_addr = 32'd0; mem_wdata = 32'd0;
        for (int i = 0; i < 256; i++) begin
            seed[i]    = 8'($urandom);
            ref_mem[i] = seed[i];
        end

        #1 rst = 1'b0;
        #2;
        chk("rst_mem_a", ram.mem_a, 32'd0);
        chk("rst_mem_dout", {24'd0, ram.mem_dout}, 32'd0);
        chk("rst_mem_wr", {31'd0, ram.mem_wr}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_en", {31'd0, wb_rd_enable}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        ram_clr = 1'b0;
        rst     = 1'b1;

        issue_alu(32'h12345678, 5'd5, 1'b1);
        issue_mem(1'b1, 3'b010, 32'h00001000, 32'hAABBCCDD, 0, 0);
        issue_mem(1'b1, 3'b000, 32'h00000020, 32'h00000080, 0, 0);
        issue_mem(1'b0, 3'b000, 32'h00000020, 32'd0, 0, 0);
        issue_mem(1'b0, 3'b100, 32'h00000020, 32'd0, 0, 0);
        issue_mem(1'b1, 3'b010, 32'hFFFFFFFE, 32'h44332211, 0, 0);
        issue_mem(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, 0, 0);
        issue_mem(1'b1, 3'b001, 32'h00000040, 32'h00009234, 0, 0);
        issue_mem(1'b0, 3'b001, 32'h00000040, 32'd0, 2, 2);

        // reset in the middle of a word store: bytes 0 and 1 land, byte 2 must not
        for (int k = 0; k < 2; k++) begin
            wr_t x;
            x.a = 32'h80 + 32'(k);
            x.d = 8'(32'h55667788 >> (8 * k));
            wr_q.push_back(x);
            ref_mem[x.a[7:0]] = x.d;
        end
        ex_rd_enable = 1'b0; mem_valid = 1'b1; mem_we = 1'b1; mem_funct3 = 3'b010;
        mem_addr = 32'h80; mem_wdata = 32'h55667788;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        chk("midrst_mem_wr", {31'd0, ram.mem_wr}, 32'd0);
        chk("midrst_mem_a", ram.mem_a, 32'd0);
        chk("midrst_mem_dout", {24'd0, ram.mem_dout}, 32'd0);
        mem_valid = 1'b0; mem_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        issue_alu(32'hCAFEF00D, 5'd7, 1'b1);
        issue_mem(1'b0, 3'b010, 32'h00000080, 32'd0, 0, 0);

        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                issue_alu($urandom, 5'($urandom), 1'($urandom));
            end else begin
                we = 1'($urandom);
                case ($urandom_range(0, 7))
                    0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
                    4: f3 = 3'b101; 5: f3 = 3'b011; 6: f3 = 3'b110; default: f3 = 3'b111;
                endcase
                if ($urandom_range(0, 3) == 0) addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
                else                           addr = $urandom;
                s    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
                s    = we ? s + 1 : s + 2;
                lows = $urandom_range(0, 2);
                issue_mem(we, f3, addr, $urandom, lows, $urandom_range(0, s - 1));
            end
        end

        repeat (2) @(negedge clk);
        chk("wb_q_left", 32'(wb_q.size()), 32'd0);
        chk("wr_q_left", 32'(wr_q.size()), 32'd0);
        chk("alu_q_left", 32'(alu_q.size()), 32'd0);
        summary_and_finish();
    end

endmodule
